// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if
//   Bundles the requester-side handshake and the shared peripheral port of
//   io_bus_arbiter into one interface.
//
//   Requester side (packed, requester i owns slice [16i+15:16i] of the
//   16-bit-per-requester buses):
//     req_valid, req_write, req_addr, req_wdata -> requests into the arbiter
//     req_lock (only with IO_ARB_LOCK_EN)       -> lock request per requester
//     resp_valid, resp_rdata                    -> completion back to requesters
//   Peripheral side:
//     io_waddr, io_raddr, io_wdata, io_wenable  -> driven by the arbiter
//     io_rdata                                  -> returned by the target
//
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the target port)
//     master - the environment's view (requesters plus target)
//
//   Optional feature macro: IO_ARB_LOCK_EN adds req_lock.
interface io_bus_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [16*NREQ-1:0] req_addr;
  logic [16*NREQ-1:0] req_wdata;
`ifdef IO_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif
  logic [NREQ-1:0]    resp_valid;
  logic [15:0]        resp_rdata;
  logic [15:0]        io_waddr;
  logic [15:0]        io_raddr;
  logic [15:0]        io_wdata;
  logic               io_wenable;
  logic [15:0]        io_rdata;

`ifdef IO_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_lock, io_rdata,
    output resp_valid, resp_rdata, io_waddr, io_raddr, io_wdata, io_wenable
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_lock, io_rdata,
    input  resp_valid, resp_rdata, io_waddr, io_raddr, io_wdata, io_wenable
  );
`else
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, io_rdata,
    output resp_valid, resp_rdata, io_waddr, io_raddr, io_wdata, io_wenable
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, io_rdata,
    input  resp_valid, resp_rdata, io_waddr, io_raddr, io_wdata, io_wenable
  );
`endif
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one io_interface-style peripheral port among NREQ requesters with
//   round-robin arbitration and one transaction in flight at a time. Writes
//   get a single-cycle io_wenable strobe; reads wait a fixed READ_LATENCY
//   for the target's registered data. Each transaction ends with a one-cycle
//   resp_valid pulse to the requester that won it.
//
//   Parameters:
//     NREQ         number of requesters (2..4)
//     READ_LATENCY cycles from io_raddr driven to io_rdata valid (1..4)
//
//   Ports:
//     clock    system clock, rising edge
//     reset    synchronous active-high reset
//     bus      io_bus_arbiter_if.slave: requests, responses, target port
//     busy     high whenever the FSM is not in IDLE
//     grant_id index of the current or last granted requester
//
//   Optional feature macro: IO_ARB_LOCK_EN
//     Adds req_lock. A granted requester holding req_lock in its RESP cycle
//     keeps exclusive access until it drops req_lock in a RESP cycle or
//     drops req_valid in an IDLE cycle.
module io_bus_arbiter #(
  parameter int NREQ         = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  io_bus_arbiter_if.slave bus,
  output logic            busy,
  output logic [1:0]      grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [1:0]      r_rrPtr;
  logic [1:0]      r_grantId;
  logic            r_isWrite;
  logic [1:0]      r_waitCnt;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rdata;

  logic [NREQ-1:0] w_eligible;
  logic [1:0]      w_ptr;
  logic [1:0]      w_winner;
  logic            w_found;
  logic [15:0]     w_addrSel;
  logic [15:0]     w_wdataSel;
  logic            w_writeSel;

`ifdef IO_ARB_LOCK_EN
  logic            r_lock;
  logic            w_lockRelease;
  logic            w_holderValid;
  logic            w_lockReq;
`endif

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (int'(idx) == NREQ - 1) ? 2'd0 : idx + 2'd1;
  endfunction

`ifdef IO_ARB_LOCK_EN
  // Request and lock bits of the lock holder (the last granted requester).
  always_comb begin
    w_holderValid = 1'b0;
    w_lockReq     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grantId == 2'(i)) begin
        w_holderValid = bus.req_valid[i];
        w_lockReq     = bus.req_lock[i];
      end
    end
  end
`endif

  // Round-robin pick: first eligible requester scanning from w_ptr upward.
  // While locked only the holder is eligible; if the holder has gone quiet
  // the lock drops and the scan starts just past it in the same cycle.
  always_comb begin
    w_eligible = bus.req_valid;
    w_ptr      = r_rrPtr;
`ifdef IO_ARB_LOCK_EN
    w_lockRelease = 1'b0;
    if (r_lock) begin
      if (w_holderValid) begin
        for (int i = 0; i < NREQ; i++) begin
          w_eligible[i] = (r_grantId == 2'(i));
        end
      end else begin
        w_lockRelease = 1'b1;
        w_ptr         = nextIdx(r_grantId);
      end
    end
`endif
    w_found  = 1'b0;
    w_winner = w_ptr;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (i == (int'(w_ptr) + k) % NREQ) && w_eligible[i]) begin
          w_found  = 1'b1;
          w_winner = 2'(i);
        end
      end
    end
  end

  // Unpack the winner's write flag, address and data.
  always_comb begin
    w_addrSel  = '0;
    w_wdataSel = '0;
    w_writeSel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == 2'(i)) begin
        w_addrSel  = bus.req_addr[16*i +: 16];
        w_wdataSel = bus.req_wdata[16*i +: 16];
        w_writeSel = bus.req_write[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Reads always pass through WAIT: the target registers io_raddr and
  // presents data READ_LATENCY cycles after ACCESS, so it is captured in
  // the last of READ_LATENCY WAIT cycles.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_found) w_stateNext = ACCESS;
      ACCESS:  w_stateNext = r_isWrite ? RESP : WAIT;
      WAIT:    if (r_waitCnt == 2'd0) w_stateNext = RESP;
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr   <= 2'd0;
      r_grantId <= 2'd0;
      r_isWrite <= 1'b0;
      r_waitCnt <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef IO_ARB_LOCK_EN
      r_lock    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef IO_ARB_LOCK_EN
          if (w_lockRelease) begin
            r_lock  <= 1'b0;
            r_rrPtr <= nextIdx(r_grantId);
          end
`endif
          if (w_found) begin
            r_grantId <= w_winner;
            r_isWrite <= w_writeSel;
            r_addr    <= w_addrSel;
            r_wdata   <= w_wdataSel;
            r_waitCnt <= 2'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_waitCnt == 2'd0) begin
            r_rdata <= bus.io_rdata;
          end else begin
            r_waitCnt <= r_waitCnt - 2'd1;
          end
        end
        RESP: begin
`ifdef IO_ARB_LOCK_EN
          // Holding the lock freezes the pointer; the holder stays eligible.
          if (w_lockReq) begin
            r_lock <= 1'b1;
          end else begin
            r_lock  <= 1'b0;
            r_rrPtr <= nextIdx(r_grantId);
          end
`else
          r_rrPtr <= nextIdx(r_grantId);
`endif
        end
        default: ;
      endcase
    end
  end

  // Response pulse goes only to the granted requester.
  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.resp_valid[i] = (r_state == RESP) && (r_grantId == 2'(i));
    end
  end

  assign bus.io_wenable = (r_state == ACCESS) && r_isWrite;
  assign bus.io_waddr   = r_addr;
  assign bus.io_raddr   = r_addr;
  assign bus.io_wdata   = r_wdata;
  assign bus.resp_rdata = r_rdata;
  assign busy           = (r_state != IDLE);
  assign grant_id       = r_grantId;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Self-checking bench for io_bus_arbiter with NREQ=2, READ_LATENCY=3.
//   A behavioural target registers io_raddr through READ_LATENCY stages and
//   returns 0x1234 for address 0x0022, otherwise address ^ 0xA5A5.
//   Expected responses go into a queue as requests are driven; a monitor
//   pops and compares them on every resp_valid pulse. Each test task also
//   checks the cycle-by-cycle behaviour of its own scenario.
//   Optional feature macro: IO_ARB_LOCK_EN enables test_lock.
module tb_io_bus_arbiter;
  localparam int NREQ = 2;
  localparam int RL   = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;

  io_bus_arbiter_if #(.NREQ(NREQ)) bus();

  io_bus_arbiter #(.NREQ(NREQ), .READ_LATENCY(RL)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  // Target model: registered read path RL cycles deep.
  function automatic logic [15:0] targetData(input logic [15:0] a);
    return (a == 16'h0022) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  logic [15:0] rdPipe [RL];
  always @(posedge clock) begin
    rdPipe[0] <= targetData(bus.io_raddr);
    for (int k = 1; k < RL; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign bus.io_rdata = rdPipe[RL-1];

  typedef struct {
    int          id;
    bit          isRead;
    logic [15:0] data;
  } exp_t;

  exp_t            sbQ[$];
  exp_t            mExp;
  logic [NREQ-1:0] mWant;
  int              nTests = 0;
  int              nFail  = 0;

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (bus.resp_valid !== '0) begin
      nTests++;
      if (sbQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL sb_unexpected resp_valid=%b, nothing outstanding", bus.resp_valid);
      end else begin
        mExp  = sbQ.pop_front();
        mWant = NREQ'(1) << mExp.id;
        if (bus.resp_valid !== mWant) begin
          nFail++;
          $display("[TB] FAIL sb_resp_valid got %b want %b", bus.resp_valid, mWant);
        end
        if (mExp.isRead) begin
          nTests++;
          if (bus.resp_rdata !== mExp.data) begin
            nFail++;
            $display("[TB] FAIL sb_resp_rdata got %h want %h", bus.resp_rdata, mExp.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input int id, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid[id]         = 1'b1;
    bus.req_write[id]         = wr;
    bus.req_addr[16*id +: 16]  = a;
    bus.req_wdata[16*id +: 16] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    nTests++; if (grant_id !== 2'd0) begin nFail++; $display("[TB] FAIL rst_grant_id got %0d want 0", grant_id); end
    nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL rst_resp_valid got %b want 00", bus.resp_valid); end
    nTests++; if (bus.resp_rdata !== 16'h0) begin nFail++; $display("[TB] FAIL rst_resp_rdata got %h want 0000", bus.resp_rdata); end
    nTests++; if (bus.io_waddr !== 16'h0) begin nFail++; $display("[TB] FAIL rst_io_waddr got %h want 0000", bus.io_waddr); end
    nTests++; if (bus.io_raddr !== 16'h0) begin nFail++; $display("[TB] FAIL rst_io_raddr got %h want 0000", bus.io_raddr); end
    nTests++; if (bus.io_wdata !== 16'h0) begin nFail++; $display("[TB] FAIL rst_io_wdata got %h want 0000", bus.io_wdata); end
    nTests++; if (bus.io_wenable !== 1'b0) begin nFail++; $display("[TB] FAIL rst_io_wenable got %b want 0", bus.io_wenable); end
  endtask

  task automatic test_write();
    tick();
    setReq(0, 1'b1, 16'h0010, 16'hBEEF);
    sbQ.push_back('{id: 0, isRead: 1'b0, data: 16'h0000});
    @(negedge clock);
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL wr_busy_c0 got %b want 0", busy); end
    tick();
    @(negedge clock);
    nTests++; if (bus.io_wenable !== 1'b1) begin nFail++; $display("[TB] FAIL wr_wenable_c1 got %b want 1", bus.io_wenable); end
    nTests++; if (bus.io_waddr !== 16'h0010) begin nFail++; $display("[TB] FAIL wr_waddr got %h want 0010", bus.io_waddr); end
    nTests++; if (bus.io_wdata !== 16'hBEEF) begin nFail++; $display("[TB] FAIL wr_wdata got %h want beef", bus.io_wdata); end
    nTests++; if (grant_id !== 2'd0) begin nFail++; $display("[TB] FAIL wr_grant got %0d want 0", grant_id); end
    nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL wr_resp_c1 got %b want 00", bus.resp_valid); end
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    nTests++; if (bus.resp_valid !== 2'b01) begin nFail++; $display("[TB] FAIL wr_resp_c2 got %b want 01", bus.resp_valid); end
    nTests++; if (bus.io_wenable !== 1'b0) begin nFail++; $display("[TB] FAIL wr_wenable_c2 got %b want 0", bus.io_wenable); end
    tick();
    @(negedge clock);
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL wr_busy_c3 got %b want 0", busy); end
    nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL wr_resp_c3 got %b want 00", bus.resp_valid); end
  endtask

  task automatic test_read();
    tick();
    setReq(1, 1'b0, 16'h0022, 16'h0000);
    sbQ.push_back('{id: 1, isRead: 1'b1, data: 16'h1234});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 5) bus.req_valid[1] = 1'b0;
      @(negedge clock);
      nTests++; if (bus.io_wenable !== 1'b0) begin nFail++; $display("[TB] FAIL rd_wenable_c%0d got %b want 0", c, bus.io_wenable); end
      if (c == 1) begin
        nTests++; if (bus.io_raddr !== 16'h0022) begin nFail++; $display("[TB] FAIL rd_raddr got %h want 0022", bus.io_raddr); end
        nTests++; if (grant_id !== 2'd1) begin nFail++; $display("[TB] FAIL rd_grant got %0d want 1", grant_id); end
      end
      if (c < 5) begin
        nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL rd_resp_c%0d got %b want 00", c, bus.resp_valid); end
        nTests++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL rd_busy_c%0d got %b want 1", c, busy); end
      end
      if (c == 5) begin
        nTests++; if (bus.resp_valid !== 2'b10) begin nFail++; $display("[TB] FAIL rd_resp_c5 got %b want 10", bus.resp_valid); end
      end
      if (c == 6) begin
        nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL rd_busy_c6 got %b want 0", busy); end
        nTests++; if (bus.resp_rdata !== 16'h1234) begin nFail++; $display("[TB] FAIL rd_rdata_hold got %h want 1234", bus.resp_rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]      expId;
    logic [NREQ-1:0] want;
    tick();
    setReq(0, 1'b1, 16'h0100, 16'h1111);
    setReq(1, 1'b1, 16'h0200, 16'h2222);
    for (int t = 0; t < 6; t++) sbQ.push_back('{id: t % 2, isRead: 1'b0, data: 16'h0000});
    for (int t = 0; t < 6; t++) begin
      expId = 2'(t % 2);
      want  = NREQ'(1) << expId;
      @(negedge clock);
      nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_idle_t%0d got busy %b want 0", t, busy); end
      tick();
      @(negedge clock);
      nTests++; if (grant_id !== expId) begin nFail++; $display("[TB] FAIL b2b_grant_t%0d got %0d want %0d", t, grant_id, expId); end
      nTests++; if (bus.io_wenable !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_wenable_t%0d got %b want 1", t, bus.io_wenable); end
      nTests++; if (bus.io_waddr !== (expId == 2'd1 ? 16'h0200 : 16'h0100)) begin nFail++; $display("[TB] FAIL b2b_waddr_t%0d got %h", t, bus.io_waddr); end
      nTests++; if (bus.io_wdata !== (expId == 2'd1 ? 16'h2222 : 16'h1111)) begin nFail++; $display("[TB] FAIL b2b_wdata_t%0d got %h", t, bus.io_wdata); end
      tick();
      if (t == 5) bus.req_valid = '0;
      @(negedge clock);
      nTests++; if (bus.resp_valid !== want) begin nFail++; $display("[TB] FAIL b2b_resp_t%0d got %b want %b", t, bus.resp_valid, want); end
      tick();
    end
    @(negedge clock);
    nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL b2b_resp_end got %b want 00", bus.resp_valid); end
  endtask

  task automatic test_reset_mid();
    tick();
    setReq(0, 1'b1, 16'h0300, 16'h3333);
    sbQ.push_back('{id: 0, isRead: 1'b0, data: 16'h0000});
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    setReq(1, 1'b0, 16'h0040, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_busy got %b want 0", busy); end
    nTests++; if (grant_id !== 2'd0) begin nFail++; $display("[TB] FAIL rmid_grant got %0d want 0", grant_id); end
    nTests++; if (bus.io_raddr !== 16'h0) begin nFail++; $display("[TB] FAIL rmid_raddr got %h want 0000", bus.io_raddr); end
    for (int c = 0; c < 4; c++) begin
      nTests++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("[TB] FAIL rmid_noresp_c%0d got %b want 00", c, bus.resp_valid); end
      nTests++; if (bus.io_wenable !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_wenable_c%0d got %b want 0", c, bus.io_wenable); end
      tick();
      @(negedge clock);
    end
    setReq(0, 1'b1, 16'h0310, 16'h3131);
    setReq(1, 1'b1, 16'h0320, 16'h3232);
    sbQ.push_back('{id: 0, isRead: 1'b0, data: 16'h0000});
    sbQ.push_back('{id: 1, isRead: 1'b0, data: 16'h0000});
    tick();
    @(negedge clock);
    nTests++; if (grant_id !== 2'd0) begin nFail++; $display("[TB] FAIL rmid_first_grant got %0d want 0", grant_id); end
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    @(negedge clock);
    nTests++; if (grant_id !== 2'd1) begin nFail++; $display("[TB] FAIL rmid_second_grant got %0d want 1", grant_id); end
    tick();
    bus.req_valid = '0;
    @(negedge clock);
  endtask

  task automatic test_drop();
    int strobes;
    strobes = 0;
    tick();
    setReq(0, 1'b1, 16'h0500, 16'h5555);
    sbQ.push_back('{id: 0, isRead: 1'b0, data: 16'h0000});
    @(negedge clock);
    if (bus.io_wenable === 1'b1) strobes++;
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    if (bus.io_wenable === 1'b1) strobes++;
    nTests++; if (bus.io_wdata !== 16'h5555) begin nFail++; $display("[TB] FAIL drop_wdata got %h want 5555", bus.io_wdata); end
    tick();
    @(negedge clock);
    if (bus.io_wenable === 1'b1) strobes++;
    nTests++; if (bus.resp_valid !== 2'b01) begin nFail++; $display("[TB] FAIL drop_resp got %b want 01", bus.resp_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clock);
      if (bus.io_wenable === 1'b1) strobes++;
    end
    nTests++; if (strobes !== 1) begin nFail++; $display("[TB] FAIL drop_strobe_count got %0d want 1", strobes); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL drop_busy_end got %b want 0", busy); end
  endtask

  task automatic test_rdata_hold();
    tick();
    setReq(0, 1'b0, 16'h0044, 16'h0000);
    sbQ.push_back('{id: 0, isRead: 1'b1, data: 16'hA5E1});
    repeat (5) tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    nTests++; if (bus.resp_valid !== 2'b01) begin nFail++; $display("[TB] FAIL hold_rd_resp got %b want 01", bus.resp_valid); end
    tick();
    setReq(1, 1'b1, 16'h0600, 16'h6666);
    sbQ.push_back('{id: 1, isRead: 1'b0, data: 16'h0000});
    tick();
    tick();
    bus.req_valid[1] = 1'b0;
    @(negedge clock);
    nTests++; if (bus.resp_valid !== 2'b10) begin nFail++; $display("[TB] FAIL hold_wr_resp got %b want 10", bus.resp_valid); end
    tick();
    @(negedge clock);
    nTests++; if (bus.resp_rdata !== 16'hA5E1) begin nFail++; $display("[TB] FAIL hold_rdata got %h want a5e1", bus.resp_rdata); end
  endtask

`ifdef IO_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] expIds [4];
    expIds[0] = 2'd1; expIds[1] = 2'd1; expIds[2] = 2'd1; expIds[3] = 2'd0;
    tick();
    setReq(0, 1'b1, 16'h0700, 16'h7070);
    sbQ.push_back('{id: 0, isRead: 1'b0, data: 16'h0000});
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    setReq(0, 1'b1, 16'h0710, 16'h7171);
    setReq(1, 1'b1, 16'h0720, 16'h7272);
    bus.req_lock[1] = 1'b1;
    for (int t = 0; t < 4; t++) sbQ.push_back('{id: int'(expIds[t]), isRead: 1'b0, data: 16'h0000});
    for (int t = 0; t < 4; t++) begin
      if (t == 2) bus.req_lock[1] = 1'b0;
      tick();
      @(negedge clock);
      nTests++; if (grant_id !== expIds[t]) begin nFail++; $display("[TB] FAIL lock_grant_t%0d got %0d want %0d", t, grant_id, expIds[t]); end
      tick();
      if (t == 3) bus.req_valid = '0;
      tick();
    end
    bus.req_lock = '0;
    @(negedge clock);
  endtask
`endif

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
`ifdef IO_ARB_LOCK_EN
    bus.req_lock   = '0;
`endif
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_rdata_hold();
`ifdef IO_ARB_LOCK_EN
    test_lock();
`endif
    repeat (4) tick();
    nTests++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL sb_leftover got %0d outstanding want 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
